seg7_frame_decoder: RTL and testbench

SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

---
 rtl/seg7_frame_decoder.sv | 149 ++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_frame_decoder
//  Brief    : Receives a serial 7-bit seven-segment frame (segment a first,
//             g last), decodes it to a digit 0..8 and presents the result
//             as a thermometer code or as a status word on io_out.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_frame_decoder (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] ALL_ONES = 8'hFF;

    // Field slices of the packed input port
    logic clk;
    logic rst;
    logic sdata;
    logic svalid;
    logic sync;
    logic mode;

    assign clk    = io_in[0];
    assign rst    = io_in[1];
    assign sdata  = io_in[2];
    assign svalid = io_in[3];
    assign sync   = io_in[4];
    assign mode   = io_in[5];

    // io_in[7:6] carry no function
    logic unused_in;
    assign unused_in = &{1'b0, io_in[7:6]};

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [3:0] count;
    logic       err;
    logic       vld;

    logic [3:0] dec_val;
    logic       dec_ok;
    logic       busy;
    logic [7:0] therm;

    // Pattern-to-digit lookup on the fully assembled frame (gfedcba)
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'd0;
        case (shreg)
            7'h3F:   dec_val = 4'd0;
            7'h06:   dec_val = 4'd1;
            7'h5B:   dec_val = 4'd2;
            7'h4F:   dec_val = 4'd3;
            7'h66:   dec_val = 4'd4;
            7'h6D:   dec_val = 4'd5;
            7'h7D:   dec_val = 4'd6;
            7'h07:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            default: dec_ok  = 1'b0;
        endcase
    end

    // Frame receiver FSM; bits shift in at the top so the first (segment a)
    // ends up in bit 0 once all seven have arrived
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 7'd0;
            count   <= 4'd0;
            err     <= 1'b0;
            vld     <= 1'b0;
        end else begin
            vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (svalid) begin
                        shreg   <= {sdata, 6'd0};
                        bit_cnt <= 3'd1;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (sync) begin
                        // Abandon the partial frame; a bit sampled now starts the new one
                        if (svalid) begin
                            shreg   <= {sdata, 6'd0};
                            bit_cnt <= 3'd1;
                        end else begin
                            shreg   <= 7'd0;
                            bit_cnt <= 3'd0;
                            state   <= IDLE;
                        end
                    end else if (svalid) begin
                        shreg <= {sdata, shreg[6:1]};
                        if (bit_cnt == 3'd6) begin
                            bit_cnt <= 3'd7;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (dec_ok) begin
                        count <= dec_val;
                        err   <= 1'b0;
                        vld   <= 1'b1;
                    end else begin
                        err   <= 1'b1;
                    end
                    // A bit arriving during decode is segment a of the next frame
                    if (svalid) begin
                        shreg   <= {sdata, 6'd0};
                        bit_cnt <= 3'd1;
                        state   <= RECV;
                    end else begin
                        shreg   <= 7'd0;
                        bit_cnt <= 3'd0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= 3'd0;
                    shreg   <= 7'd0;
                end
            endcase
        end
    end

    // Output view: thermometer of count, or the status word; mode is the only
    // combinational input on this path
    always_comb begin
        busy   = (state == RECV);
        therm  = ~(ALL_ONES << count);
        io_out = mode ? {1'b0, busy, err, vld, count} : therm;
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_frame_decoder
//  Brief    : Self-checking bench for seg7_frame_decoder: directed frames
//             with literal expectations plus randomized frames compared each
//             cycle against a frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_frame_decoder;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       sdata  = 1'b0;
    logic       svalid = 1'b0;
    logic       sync   = 1'b0;
    logic       mode   = 1'b0;
    logic [1:0] spare  = 2'b00;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {spare, mode, sync, svalid, sdata, rst, clk};

    seg7_frame_decoder dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // ---------------- reference model (frame level) ----------------
    logic [6:0] codes [9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F};
    int         held [$];       // bits of the frame in progress, segment a first
    bit         pend;           // a complete frame waits to be decoded next edge
    logic [6:0] pend_pat;
    int         m_count = 0;
    bit         m_err   = 1'b0;
    bit         m_vld   = 1'b0;
    logic [7:0] exp_v;

    function automatic int lookup(logic [6:0] p);
        for (int i = 0; i < 9; i++)
            if (codes[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [7:0] exp_out(bit md);
        logic [7:0] r;
        r = 8'h00;
        if (md) r = {1'b0, (held.size() != 0), m_err, m_vld, 4'(m_count)};
        else for (int i = 0; i < m_count; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        int idx;
        if (rst) begin
            held.delete();
            pend    = 1'b0;
            m_count = 0;
            m_err   = 1'b0;
            m_vld   = 1'b0;
        end else begin
            m_vld = 1'b0;
            if (pend) begin
                idx = lookup(pend_pat);
                if (idx >= 0) begin
                    m_count = idx;
                    m_err   = 1'b0;
                    m_vld   = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                pend = 1'b0;
            end
            if (sync) held.delete();
            if (svalid) held.push_back(int'(sdata));
            if (held.size() == 7) begin
                for (int i = 0; i < 7; i++) pend_pat[i] = held[i][0];
                pend = 1'b1;
                held.delete();
            end
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    // ---------------- per-cycle compare ----------------
    task automatic compare_now();
        exp_v = exp_out(mode);
        total++;
        if (io_out !== exp_v) begin
            bad++;
            $display("FAIL cycle_compare t=%0t mode=%0b got=%02h want=%02h",
                     $time, mode, io_out, exp_v);
        end
    endtask

    always @(negedge clk) if (check_en) compare_now();

    // cycle counter and vld pulse recorder for back-to-back timing
    int cyc = 0;
    int vld_q [$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (check_en && mode && io_out[4]) vld_q.push_back(cyc);

    // ---------------- helpers ----------------
    task automatic check(string name, logic [7:0] got, logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%02h want=%02h", name, got, want);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic drive(bit sv, bit sd, bit sy);
        @(negedge clk);
        #2;
        svalid = sv;
        sdata  = sd;
        sync   = sy;
    endtask

    task automatic send(logic [6:0] pat, int gap);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, pat[i], 1'b0);
            if (i < 6) for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic view(bit md);
        mode = md;
        #1;
    endtask

    // ---------------- stimulus ----------------
    int         base;
    int         g;
    logic [6:0] pat;

    initial begin
        @(posedge clk);
        #1;
        check_en = 1'b1;
        view(1'b0); check("reset_therm",  io_out, 8'h00);
        view(1'b1); check("reset_status", io_out, 8'h00);
        @(negedge clk); #2; rst = 1'b0;

        // 0x5B contiguous -> digit 2
        view(1'b0);
        send(7'h5B, 0);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("d2_therm", io_out, 8'h03);
        view(1'b1); check("d2_status_vld", io_out, 8'h12);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("d2_status_after", io_out, 8'h02);

        // 0x7F with 3-cycle gaps -> digit 8
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            if (i < 6) repeat (3) drive(1'b0, 1'b0, 1'b0);
            if (i == 3) begin
                peek();
                check("gap_busy", {7'd0, io_out[6]}, 8'h01);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("d8_status_vld", io_out, 8'h18);
        view(1'b0); check("d8_therm", io_out, 8'hFF);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        view(1'b1); check("d8_vld_single", io_out, 8'h08);

        // count 5, then invalid 0x00, then 0x06
        send(7'h6D, 0);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("d5_status_vld", io_out, 8'h15);
        send(7'h00, 0);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("invalid_status", io_out, 8'h25);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("invalid_held", io_out, 8'h25);
        send(7'h06, 1);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("d1_status_vld", io_out, 8'h11);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("d1_status_after", io_out, 8'h01);

        // 4 bits, sync carrying segment a, then rest of 0x4F
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        pat = 7'h4F;
        drive(1'b1, pat[0], 1'b1);
        for (int i = 1; i < 7; i++) drive(1'b1, pat[i], 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("sync_restart_d3", io_out, 8'h13);

        // back-to-back 0x66 then 0x07 on 14 consecutive valid cycles
        vld_q.delete();
        pat = 7'h66;
        drive(1'b1, pat[0], 1'b0);
        base = cyc;
        for (int i = 1; i < 7; i++) drive(1'b1, pat[i], 1'b0);
        pat = 7'h07;
        for (int i = 0; i < 7; i++) drive(1'b1, pat[i], 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("b2b_d7_status", io_out, 8'h17);
        check_int("b2b_vld_count", vld_q.size(), 2);
        if (vld_q.size() == 2) begin
            check_int("b2b_vld1_cycle", vld_q[0] - base, 8);
            check_int("b2b_vld2_cycle", vld_q[1] - base, 15);
        end

        // asynchronous reset mid-frame while count=8
        view(1'b0);
        send(7'h7F, 0);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("pre_reset_therm", io_out, 8'hFF);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_therm", io_out, 8'h00);
        view(1'b1); check("async_reset_status", io_out, 8'h00);
        @(negedge clk); #2; rst = 1'b0; svalid = 1'b0;
        send(7'h3F, 0);
        drive(1'b0, 1'b0, 1'b0);
        peek();
        check("post_reset_d0_status", io_out, 8'h10);
        view(1'b0); check("post_reset_d0_therm", io_out, 8'h00);

        // randomized frames with gaps, stray syncs, mode flips and resets
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(0, 3) == 0) pat = 7'($urandom);
            else                           pat = codes[$urandom_range(0, 8)];
            for (int i = 0; i < 7; i++) begin
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++)
                    drive(1'b0, 1'($urandom), ($urandom_range(0, 30) == 0));
                mode  = 1'($urandom);
                spare = 2'($urandom);
                drive(1'b1, pat[i], ($urandom_range(0, 40) == 0));
            end
            if ($urandom_range(0, 15) == 0) begin
                @(posedge clk);
                #3;
                rst = 1'b1;
                @(negedge clk);
                #2;
                rst = 1'b0;
            end
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        peek();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
